word_narrow: RTL and testbench

WORD_NARROW -- requirements
Module: word_narrow

---
 rtl/word_narrow_if.sv | 33 +++
 rtl/word_narrow.sv | 95 +++++++++
 tb/tb_word_narrow.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/word_narrow_if.sv
// Handshake bundle for word_narrow: input word stream, narrowed result stream, overflow counter.
// Latency: none (wires only).
// Backpressure: carries in_ready/out_ready; slave = the narrowing block, master = its environment.
//
// Signals:
//   in_valid/in_ready/in_data/in_signed  upstream word and its range mode
//   out_valid/out_ready/out_data/out_ovf narrowed result and overflow flag
//   ovf_count/ovf_clear                  overflow counter and its clear
interface word_narrow_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_signed;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_ovf;
    logic [15:0]      ovf_count;
    logic             ovf_clear;

    modport slave (
        input  in_valid, in_data, in_signed, out_ready, ovf_clear,
        output in_ready, out_valid, out_data, out_ovf, ovf_count
    );

    modport master (
        output in_valid, in_data, in_signed, out_ready, ovf_clear,
        input  in_ready, out_valid, out_data, out_ovf, ovf_count
    );
endinterface

// File: rtl/word_narrow.sv
// Narrows IN_W-bit words to OUT_W bits with signed/unsigned range check and overflow counting.
// Latency: 1 cycle from acceptance into an empty FIFO to out_valid.
// Backpressure: 2-entry result FIFO; in_ready = fewer than 2 held, registered (no path from out_ready).
//
// Ports: clock, reset (synchronous, active-high), bus (word_narrow_if.slave).
// Optional build macro WORD_NARROW_SATURATE_EN: overflowed words clamp to the
// OUT_W range limit instead of keeping their low OUT_W bits. Only IN_W > OUT_W is supported.
module word_narrow #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16
) (
    input  logic         clock,
    input  logic         reset,
    word_narrow_if.slave bus
);

    // Range-check slices: signed needs the top bits down to the new sign bit
    // to be a uniform sign extension; unsigned needs everything above OUT_W zero.
    logic [IN_W-OUT_W:0]   hi_s;
    logic [IN_W-OUT_W-1:0] hi_u;
    logic                  res_ovf;
    logic [OUT_W-1:0]      res_data;

    logic [OUT_W:0] mem [2];   // {data, ovf}
    logic           wr_ptr;
    logic           rd_ptr;
    logic [1:0]     count;
    logic [15:0]    ovf_cnt;
    logic           push;
    logic           pop;

    always_comb begin
        hi_s     = bus.in_data[IN_W-1:OUT_W-1];
        hi_u     = bus.in_data[IN_W-1:OUT_W];
        res_ovf  = 1'b0;
        res_data = bus.in_data[OUT_W-1:0];
        if (bus.in_signed) begin
            res_ovf = !((&hi_s) || !(|hi_s));
        end else begin
            res_ovf = |hi_u;
        end
`ifdef WORD_NARROW_SATURATE_EN
        if (res_ovf) begin
            if (bus.in_signed) begin
                // Clamp toward the side the original value lies on.
                res_data = bus.in_data[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                               : {1'b0, {(OUT_W-1){1'b1}}};
            end else begin
                res_data = {OUT_W{1'b1}};
            end
        end
`endif
    end

    assign bus.in_ready  = (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign bus.out_data  = mem[rd_ptr][OUT_W:1];
    assign bus.out_ovf   = mem[rd_ptr][0];
    assign bus.ovf_count = ovf_cnt;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            // Entries are cleared so the head reads as zero after reset.
            mem[0]  <= '0;
            mem[1]  <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            ovf_cnt <= 16'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {res_data, res_ovf};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            // Clear wins over a same-cycle increment; the counter sticks at all-ones.
            if (bus.ovf_clear) begin
                ovf_cnt <= 16'd0;
            end else if (push && res_ovf && (ovf_cnt != 16'hFFFF)) begin
                ovf_cnt <= ovf_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_word_narrow.sv
// Self-checking bench for word_narrow: scoreboard of expected {data, ovf} pushed on
// acceptance and popped when the block delivers a result; scenario tasks check
// reset state, narrowing patterns, backpressure, counter saturation and mid-run reset.
module tb_word_narrow;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [16:0] sbq [$];
    logic [15:0] exp_cnt;
    logic        stall_prev;
    logic [16:0] held;

    word_narrow_if #(.IN_W(32), .OUT_W(16)) bus ();

    word_narrow #(.IN_W(32), .OUT_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference narrowing: range test done arithmetically on the full word.
    function automatic logic [16:0] model(input logic [31:0] d, input logic s);
        logic        ovf;
        logic [15:0] q;
        if (s) ovf = ($signed(d) > 32'sd32767) || ($signed(d) < -32'sd32768);
        else   ovf = (d > 32'd65535);
        q = d[15:0];
`ifdef WORD_NARROW_SATURATE_EN
        if (ovf) q = s ? (d[31] ? 16'h8000 : 16'h7FFF) : 16'hFFFF;
`endif
        return {q, ovf};
    endfunction

    // Output monitor: pops the scoreboard on each output transfer and checks
    // that a stalled result does not change.
    always @(negedge clock) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                n_checks++;
                if ({bus.out_data, bus.out_ovf} !== held || bus.out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stall_stable: got valid=%b %h/%b need %h/%b",
                             bus.out_valid, bus.out_data, bus.out_ovf, held[16:1], held[0]);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                if (sbq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got %h/%b, none expected",
                             bus.out_data, bus.out_ovf);
                end else begin
                    logic [16:0] e;
                    e = sbq.pop_front();
                    if ({bus.out_data, bus.out_ovf} !== e) begin
                        n_fail++;
                        $display("FAIL output_order: got %h/%b need %h/%b",
                                 bus.out_data, bus.out_ovf, e[16:1], e[0]);
                    end
                end
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            held       = {bus.out_data, bus.out_ovf};
        end
    end

    // Present a word and wait (bounded) for acceptance; leaves in_valid high.
    task automatic send(input logic [31:0] d, input logic s);
        bit done;
        done = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_signed = s;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clock);
            if (bus.in_ready) begin
                logic [16:0] e;
                e = model(d, s);
                sbq.push_back(e);
                if (bus.ovf_clear) exp_cnt = 16'd0;
                else if (e[0] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
                done = 1'b1;
            end
            @(posedge clock);
            #1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 for 20 cycles need acceptance of %h", d);
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(posedge clock);
            n++;
        end
        #1;
        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d results pending need 0", sbq.size());
        end
    endtask

    task automatic check_count(input string tag);
        @(negedge clock);
        n_checks++;
        if (bus.ovf_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL %s: got ovf_count=%h need %h", tag, bus.ovf_count, exp_cnt);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 16'h0 ||
            bus.out_ovf !== 1'b0 || bus.ovf_count !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b r=%b d=%h o=%b c=%h need 0 1 0000 0 0000",
                     bus.out_valid, bus.in_ready, bus.out_data, bus.out_ovf, bus.ovf_count);
        end
        @(posedge clock);
        #1;
    endtask

    // Sends one word into an empty FIFO and checks it shows up the next cycle.
    task automatic latency_case(input string tag, input logic [31:0] d, input logic s,
                                input logic [15:0] need_d, input logic need_o);
        send(d, s);
        idle();
        @(negedge clock);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== need_d || bus.out_ovf !== need_o) begin
            n_fail++;
            $display("FAIL %s: got v=%b d=%h o=%b need v=1 d=%h o=%b",
                     tag, bus.out_valid, bus.out_data, bus.out_ovf, need_d, need_o);
        end
        @(posedge clock);
        #1;
        drain();
    endtask

    task automatic test_narrow();
        logic [31:0] pats [8];
        logic        sgns [8];
        bus.out_ready = 1'b1;
        latency_case("signed_min_fit", 32'hFFFF8000, 1'b1, 16'h8000, 1'b0);
        check_count("count_after_fit");
`ifdef WORD_NARROW_SATURATE_EN
        latency_case("unsigned_ovf", 32'h00012345, 1'b0, 16'hFFFF, 1'b1);
`else
        latency_case("unsigned_ovf", 32'h00012345, 1'b0, 16'h2345, 1'b1);
`endif
        check_count("count_after_ovf");
`ifdef WORD_NARROW_SATURATE_EN
        latency_case("signed_pos_ovf", 32'h00008000, 1'b1, 16'h7FFF, 1'b1);
`else
        latency_case("signed_pos_ovf", 32'h00008000, 1'b1, 16'h8000, 1'b1);
`endif
        // Mixed stream, back-to-back, exercises push+pop with one entry held.
        pats = '{32'h00007FFF, 32'hFFFF7FFF, 32'h0000FFFF, 32'hFFFFFFFF,
                 32'h80000000, 32'h7FFF0000, 32'h00010000, 32'hFFFFFFFF};
        sgns = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) send(pats[i], sgns[i]);
        idle();
        drain();
        check_count("count_after_mix");
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        send(32'h00001111, 1'b0);
        send(32'h00020002, 1'b0);
        bus.in_data   = 32'hFFFFFFFE;
        bus.in_signed = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_checks++;
            if (bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL full_in_ready: got %b need 0 (cycle %0d)", bus.in_ready, i);
            end
            @(posedge clock);
            #1;
        end
        bus.out_ready = 1'b1;
        send(32'hFFFFFFFE, 1'b1);
        idle();
        drain();
        check_count("count_after_b2b");
    endtask

    task automatic test_saturate();
        int n;
        bus.out_ready = 1'b1;
        n = 65535 - int'(exp_cnt);
        for (int i = 0; i < n; i++) send(32'h00012345, 1'b0);
        idle();
        drain();
        check_count("count_at_max");
        send(32'hABCD0000, 1'b1);
        idle();
        drain();
        check_count("count_held_max");
        bus.ovf_clear = 1'b1;
        send(32'h00012345, 1'b0);
        bus.ovf_clear = 1'b0;
        idle();
        drain();
        check_count("clear_beats_incr");
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        send(32'h00030000, 1'b0);
        send(32'h00000042, 1'b0);
        idle();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        sbq.delete();
        exp_cnt = 16'd0;
        @(negedge clock);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.ovf_count !== 16'h0 ||
            bus.out_data !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got v=%b r=%b c=%h d=%h need 0 1 0000 0000",
                     bus.out_valid, bus.in_ready, bus.ovf_count, bus.out_data);
        end
        @(posedge clock);
        #1;
        // Any output now would be a discarded word leaking out.
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        latency_case("post_reset_word", 32'h00000077, 1'b1, 16'h0077, 1'b0);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        exp_cnt       = 16'd0;
        stall_prev    = 1'b0;
        held          = '0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_signed = 1'b0;
        bus.out_ready = 1'b0;
        bus.ovf_clear = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        test_reset();
        test_narrow();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
